alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameters SHALL be none; data width is fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  decoded-instruction beat offered by the register-read stage.
REQ-005 in_ready  out  1  stage can accept a beat this cycle.
REQ-006 instr  in  32  raw MIPS instruction word.
REQ-007 rs_val  in  32  register value for the rs field.
REQ-008 rt_val  in  32  register value for the rt field.
REQ-009 flush  in  1  discard all held and incoming beats.
REQ-010 out_valid  out  1  ALU operand beat available.
REQ-011 out_ready  in  1  ALU accepts the beat this cycle.
REQ-012 alu_in1, alu_in2  out  32 each  ALU operands.
REQ-013 alu_func  out  6  ALU operation code.
REQ-014 alu_shamt  out  5  shift amount, instr[10:6].
REQ-015 is_branch  out  1  alu_func is a branch-compare code.
REQ-016 illegal  out  1  instruction not supported by the ALU.

Function
REQ-017 Decode SHALL map opcode 000000 to alu_func = instr[5:0] for funct in {000000,000010,000011,000100,000110,011000,011010,100001,100010,100011,100100,100101,100110,100111,101010}, alu_in1 = rs_val, alu_in2 = rt_val.
REQ-018 Immediate ops SHALL use alu_in1 = rs_val and map: addi/addiu/lw/sw (001000/001001/100011/101011) -> 100001 sign-extended; slti 001010 -> 101010 sign-extended; andi 001100 -> 100100, ori 001101 -> 100101, xori 001110 -> 100110 zero-extended.
REQ-019 Branches SHALL map beq 000100 -> 111000, bne 000101 -> 111001 (alu_in2 = rt_val); blez 000110 -> 111010, bgtz 000111 -> 111011, opcode 000001 with rt = 00001 -> 111100 (alu_in2 = 0); is_branch = 1 for these only.
REQ-020 lui 001111 SHALL map to 111101 with alu_in2 = {16'h0, instr[15:0]}, alu_in1 = 0.
REQ-021 Any other encoding SHALL set illegal = 1, alu_func = 100001, alu_in1 = alu_in2 = 0, is_branch = 0; the beat still flows.
REQ-022 Decode SHALL be combinational on the input side; results are registered into a main register (outputs) plus one skid register.
REQ-023 Latency SHALL be exactly 1 cycle: a beat accepted at edge N is presented with out_valid = 1 after edge N when the main register is free.
REQ-024 in_ready SHALL equal ~skid_valid and SHALL be 0 while rst_n is low.
REQ-025 On an edge where out_valid = 0 or out_ready = 1, the main register SHALL load the skid entry if skid_valid, else the incoming beat if accepted, else clear out_valid.
REQ-026 An accepted beat arriving while main holds a beat and out_ready = 0 SHALL enter the skid register; ordering SHALL be strictly FIFO.
REQ-027 Outputs SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-028 flush SHALL, at the next edge, clear out_valid and skid_valid and drop any beat accepted that cycle; flush has priority over every handshake.
REQ-029 Sustained in_valid = out_ready = 1 SHALL give one beat per cycle with no bubbles.

Reset
REQ-030 rst_n low SHALL immediately clear out_valid, skid_valid, alu_in1, alu_in2, alu_func, alu_shamt, is_branch, illegal to 0, independent of clk.
REQ-031 First beat SHALL be acceptable on the first rising edge after rst_n deasserts; reset mid-transfer loses all held beats.

Structure
REQ-032 Opcode, funct and 6-bit ALU function code constants SHALL live in a shared package also used by the ALU.
REQ-033 Decode SHALL be a sub-module alu_issue_decode (pure combinational); the handshake/skid logic stays in alu_issue_stage.

Verification
REQ-034 addi rs_val = 5, imm = 16'hFFFF, out_ready = 1 -> next cycle alu_in1 = 5, alu_in2 = 32'hFFFFFFFF, alu_func = 100001.
REQ-035 ori imm = 16'h8000 -> alu_in2 = 32'h00008000, alu_func = 100101; lui imm = 16'h1234 -> alu_in2 = 32'h00001234, alu_func = 111101.
REQ-036 Three back-to-back beats with out_ready held 0 -> first two held (main+skid), in_ready = 0 on third; release out_ready -> beats emerge in order on consecutive cycles.
REQ-037 flush asserted with main and skid full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, no beat emitted.
REQ-038 instr = 32'hFC000000 -> illegal = 1, alu_func = 100001, operands 0; bgez (opcode 000001, rt = 00001) -> alu_func = 111100, is_branch = 1.
REQ-039 rst_n pulsed low mid-stream between edges -> outputs 0 immediately, first post-reset beat appears 1 cycle after acceptance.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue path: MIPS opcode/funct fields, the
// 6-bit ALU function codes consumed by the ALU, and the issued-beat layout.
package alu_issue_stage_pkg;

  localparam int unsigned DATA_W = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // REGIMM rt field selecting bgez
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // SPECIAL funct codes (instr[5:0]) that pass straight through as ALU codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU function codes
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_BEQ  = 6'b111000;
  localparam logic [5:0] ALU_BNE  = 6'b111001;
  localparam logic [5:0] ALU_BLEZ = 6'b111010;
  localparam logic [5:0] ALU_BGTZ = 6'b111011;
  localparam logic [5:0] ALU_BGEZ = 6'b111100;
  localparam logic [5:0] ALU_LUI  = 6'b111101;

  // One issued beat as presented to the ALU
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [5:0]        func;
    logic [4:0]        shamt;
    logic              is_branch;
    logic              illegal;
  } issue_beat_t;

  // True for SPECIAL funct codes the ALU executes directly
  function automatic logic rfunct_supported(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_MULT, FN_DIV,
      FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of a raw MIPS word into ALU operands and
// function code. Unsupported encodings become an ADDU of zeros flagged illegal.
module alu_issue_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  rs_val,
  input  logic [31:0]  rt_val,
  output issue_beat_t  beat
);

  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // Register values arrive already read; the rs index itself is not needed here.
  assign unused_rs_field = ^instr[25:21];

  // Opcode/funct lookup; defaults describe the illegal-instruction beat.
  always_comb begin
    beat           = '0;
    beat.func      = ALU_ADDU;
    beat.shamt     = instr[10:6];
    beat.is_branch = 1'b0;
    beat.illegal   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        if (rfunct_supported(instr[5:0])) begin
          beat.in1  = rs_val;
          beat.in2  = rt_val;
          beat.func = instr[5:0];
        end else begin
          beat.illegal = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        beat.in1  = rs_val;
        beat.in2  = imm_sext;
        beat.func = ALU_ADDU;
      end
      OP_SLTI: begin
        beat.in1  = rs_val;
        beat.in2  = imm_sext;
        beat.func = ALU_SLT;
      end
      OP_ANDI: begin
        beat.in1  = rs_val;
        beat.in2  = imm_zext;
        beat.func = ALU_AND;
      end
      OP_ORI: begin
        beat.in1  = rs_val;
        beat.in2  = imm_zext;
        beat.func = ALU_OR;
      end
      OP_XORI: begin
        beat.in1  = rs_val;
        beat.in2  = imm_zext;
        beat.func = ALU_XOR;
      end
      OP_BEQ: begin
        beat.in1       = rs_val;
        beat.in2       = rt_val;
        beat.func      = ALU_BEQ;
        beat.is_branch = 1'b1;
      end
      OP_BNE: begin
        beat.in1       = rs_val;
        beat.in2       = rt_val;
        beat.func      = ALU_BNE;
        beat.is_branch = 1'b1;
      end
      OP_BLEZ: begin
        beat.in1       = rs_val;
        beat.func      = ALU_BLEZ;
        beat.is_branch = 1'b1;
      end
      OP_BGTZ: begin
        beat.in1       = rs_val;
        beat.func      = ALU_BGTZ;
        beat.is_branch = 1'b1;
      end
      OP_REGIMM: begin
        if (rt_field == RT_BGEZ) begin
          beat.in1       = rs_val;
          beat.func      = ALU_BGEZ;
          beat.is_branch = 1'b1;
        end else begin
          beat.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        beat.in2  = imm_zext;
        beat.func = ALU_LUI;
      end
      default: begin
        beat.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming beat and registers it into a main
// output register backed by one skid register, giving 1-cycle latency and
// full throughput under valid/ready flow control.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never drops and the payload never changes while the beat waits
// for ready. flush overrides every transfer on the edge it is sampled.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [5:0]  alu_func,
  output logic [4:0]  alu_shamt,
  output logic        is_branch,
  output logic        illegal
);

  issue_beat_t dec_beat;
  issue_beat_t main_q, main_d;
  issue_beat_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept;
  logic        main_free;

  alu_issue_decode u_decode (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .beat   (dec_beat)
  );

  // The skid slot is the only thing that can stall the upstream side.
  assign in_ready  = ~skid_valid_q & rst_n;
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid_q | out_ready;

  // Next-state for main/skid: skid drains first so ordering stays FIFO.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d      = dec_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_beat;
      skid_valid_d = 1'b1;
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_in1   = main_q.in1;
  assign alu_in2   = main_q.in2;
  assign alu_func  = main_q.func;
  assign alu_shamt = main_q.shamt;
  assign is_branch = main_q.is_branch;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vectors with hand-computed results are
// pushed into an expected queue at acceptance; a monitor pops and compares on
// every output transfer and also checks output stability while stalled.
module tb_alu_issue_stage;

  localparam int W = 77;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [5:0]  alu_func;
  logic [4:0]  alu_shamt;
  logic        is_branch;
  logic        illegal;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_func  (alu_func),
    .alu_shamt (alu_shamt),
    .is_branch (is_branch),
    .illegal   (illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] f, input logic [4:0] s,
                                         input logic br, input logic il);
    return {a, b, f, s, br, il};
  endfunction

  logic [W-1:0] act;
  assign act = {alu_in1, alu_in2, alu_func, alu_shamt, is_branch, illegal};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one beat starting now (just after a rising edge) and returns just
  // after the edge that accepted it. waits counts stalled cycles.
  task automatic send(input logic [31:0] i_w, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] e1, input logic [31:0] e2, input logic [5:0] ef,
                      input logic ebr, input logic eil, output int waits);
    logic [4:0] sh;
    logic       got;
    sh       = i_w[10:6];
    instr    = i_w;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    waits    = 0;
    got      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (got) begin
      exp_q.push_back(pack(e1, e2, ef, sh, ebr, eil));
      @(posedge clk);
    end else begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck low for instr %h", i_w);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        checks++;
        if (!(out_valid && act === hold_val)) begin
          fails++;
          $display("FAIL stall_stable: got v=%b %h expected v=1 %h", out_valid, act, hold_val);
        end
      end
      hold_valid = out_valid && !out_ready && !flush;
      hold_val   = act;
      if (out_valid && out_ready && !flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h expected none", act);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL beat: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    rs_val    = '0;
    rt_val    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_payload_nonzero", {31'd0, |act}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode vectors with out_ready held high (also full throughput)
    send({6'b001000, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd9, 32'd5, 32'hFFFFFFFF, 6'b100001, 1'b0, 1'b0, w);
    check("addi_no_stall", w, 0);
    send({6'b001101, 5'd1, 5'd2, 16'h8000}, 32'h0000_00F0, 32'd0, 32'h0000_00F0, 32'h0000_8000, 6'b100101, 1'b0, 1'b0, w);
    check("ori_no_stall", w, 0);
    send({6'b001111, 5'd0, 5'd2, 16'h1234}, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'h0000_1234, 6'b111101, 1'b0, 1'b0, w);
    check("lui_no_stall", w, 0);
    send({6'b000000, 5'd1, 5'd2, 5'd3, 5'd4, 6'b100001}, 32'd100, 32'd23, 32'd100, 32'd23, 6'b100001, 1'b0, 1'b0, w);
    send({6'b000000, 5'd0, 5'd2, 5'd3, 5'd7, 6'b000000}, 32'd3, 32'h0000_0011, 32'd3, 32'h0000_0011, 6'b000000, 1'b0, 1'b0, w);
    send({6'b000000, 5'd1, 5'd0, 5'd0, 5'd0, 6'b001000}, 32'd7, 32'd8, 32'd0, 32'd0, 6'b100001, 1'b0, 1'b1, w);
    send(32'hFC000000, 32'd11, 32'd12, 32'd0, 32'd0, 6'b100001, 1'b0, 1'b1, w);
    send({6'b000001, 5'd3, 5'd1, 16'h0010}, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFE, 32'd0, 6'b111100, 1'b1, 1'b0, w);
    send({6'b000001, 5'd3, 5'd0, 16'h0010}, 32'd1, 32'd5, 32'd0, 32'd0, 6'b100001, 1'b0, 1'b1, w);
    send({6'b000100, 5'd3, 5'd4, 16'h0020}, 32'd42, 32'd43, 32'd42, 32'd43, 6'b111000, 1'b1, 1'b0, w);
    send({6'b000111, 5'd3, 5'd4, 16'h0020}, 32'd9, 32'd43, 32'd9, 32'd0, 6'b111011, 1'b1, 1'b0, w);
    send({6'b001010, 5'd3, 5'd4, 16'h8001}, 32'd1, 32'd2, 32'd1, 32'hFFFF_8001, 6'b101010, 1'b0, 1'b0, w);
    send({6'b001100, 5'd3, 5'd4, 16'hF0F0}, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0000_F0F0, 6'b100100, 1'b0, 1'b0, w);
    send({6'b101011, 5'd3, 5'd4, 16'h0004}, 32'h1000, 32'd2, 32'h1000, 32'h4, 6'b100001, 1'b0, 1'b0, w);
    check("sustained_no_stall", w, 0);

    // Backpressure: main + skid fill, third beat stalls, then drains in order
    @(posedge clk);
    #1 out_ready = 1'b0;
    send({6'b001001, 5'd1, 5'd2, 16'h0001}, 32'd10, 32'd0, 32'd10, 32'd1, 6'b100001, 1'b0, 1'b0, w);
    send({6'b001110, 5'd1, 5'd2, 16'hFF00}, 32'd20, 32'd0, 32'd20, 32'h0000_FF00, 6'b100110, 1'b0, 1'b0, w);
    check("skid_fill_no_stall", w, 0);
    @(negedge clk);
    check("third_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("held_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send({6'b000101, 5'd1, 5'd2, 16'h0003}, 32'd30, 32'd31, 32'd30, 32'd31, 6'b111001, 1'b1, 1'b0, w);
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);

    // Flush with main and skid full and a beat offered
    out_ready = 1'b0;
    send({6'b001000, 5'd1, 5'd2, 16'h0010}, 32'd1, 32'd0, 32'd1, 32'h10, 6'b100001, 1'b0, 1'b0, w);
    send({6'b001000, 5'd1, 5'd2, 16'h0020}, 32'd2, 32'd0, 32'd2, 32'h20, 6'b100001, 1'b0, 1'b0, w);
    instr    = {6'b001000, 5'd1, 5'd2, 16'h0030};
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("flush_nothing_emitted", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream, then first post-reset beat latency
    @(posedge clk);
    #1 out_ready = 1'b0;
    send({6'b001101, 5'd1, 5'd2, 16'h00AA}, 32'd5, 32'd0, 32'd5, 32'hAA, 6'b100101, 1'b0, 1'b0, w);
    send({6'b001101, 5'd1, 5'd2, 16'h00BB}, 32'd6, 32'd0, 32'd6, 32'hBB, 6'b100101, 1'b0, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_alu_in1", alu_in1, 32'd0);
    check("mid_reset_alu_in2", alu_in2, 32'd0);
    check("mid_reset_alu_func", {26'd0, alu_func}, 32'd0);
    check("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n    = 1'b1;
    instr    = {6'b001000, 5'd1, 5'd2, 16'h0007};
    rs_val   = 32'd3;
    rt_val   = 32'd0;
    in_valid = 1'b1;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pack(32'd3, 32'd7, 6'b100001, 5'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_latency", {31'd0, out_valid}, 32'd1);

    // Drain with a bounded wait
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
